// File: rtl/sdma_pingpong_mc_if.sv
// Sample-stream and host read bus of the multi-channel ping-pong capture buffer.
// The master side produces samples and read requests; the slave side is the buffer.
interface sdma_pingpong_mc_if #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 1024,
  parameter int NUM_CH     = 2
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                         sample_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] sample_data;
  logic                         rd_en;
  logic [CW-1:0]                rd_ch;
  logic [AW-1:0]                rd_addr;
  logic [15:0]                  rd_data;
  logic                         rd_valid;

  modport master (
    output sample_valid, sample_data, rd_en, rd_ch, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  sample_valid, sample_data, rd_en, rd_ch, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/sdma_pingpong_mc.sv
// Multi-channel ping-pong capture buffer: one bank fills on trigger while the host reads the other.
// Host reads return after exactly 1 cycle; no back-pressure, samples arriving during a deferred swap are counted and dropped.
module sdma_pingpong_mc #(
  parameter  int DATA_WIDTH = 12,
  parameter  int DEPTH      = 1024,
  parameter  int NUM_CH     = 2,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sdma_pingpong_mc_if.slave     bus,
  input  logic                  trig_in,
  input  logic [1:0]            trig_mode,
  input  logic                  continuous,
  input  logic                  arm,
  input  logic [7:0]            decim,
  input  logic                  reg_read,
  output logic                  has_switched,
  output logic [AW-1:0]         write_ptr,
  output logic                  write_buf,
  output logic [15:0]           overrun_cnt,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_TRIG, S_FILL, S_SWAP_PEND} state_t;

  state_t                state, state_nxt;
  logic                  trig_prev, reg_read_prev;
  logic [7:0]            dcnt, decim_q;
  logic                  fire, wr_en, swap, ovr_inc, enter_fill, arm_ok;
  logic                  last_slot;
  logic                  rd_valid_q, rd_bank_q;
  logic [CW-1:0]         rd_ch_q;
  logic [DATA_WIDTH-1:0] rd_q [2][NUM_CH];
  logic [DATA_WIDTH-1:0] rd_word;

  assign last_slot = &write_ptr;
  assign busy      = (state != S_IDLE);

  always_comb begin
    case (trig_mode)
      2'd0:    fire = 1'b1;
      2'd1:    fire = trig_in & ~trig_prev;
      2'd2:    fire = ~trig_in & trig_prev;
      default: fire = trig_in;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    swap       = 1'b0;
    ovr_inc    = 1'b0;
    enter_fill = 1'b0;
    arm_ok     = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) begin
          arm_ok    = 1'b1;
          state_nxt = S_WAIT_TRIG;
        end
      end
      S_WAIT_TRIG: begin
        if (fire) begin
          enter_fill = 1'b1;
          state_nxt  = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.sample_valid && dcnt == 8'd0) begin
          wr_en = 1'b1;
          if (last_slot) begin
            if (reg_read) state_nxt = S_SWAP_PEND;
            else          swap      = 1'b1;
          end
        end
      end
      S_SWAP_PEND: begin
        ovr_inc = bus.sample_valid;
        if (!reg_read) swap = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (swap) state_nxt = continuous ? S_WAIT_TRIG : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_prev     <= 1'b0;
      reg_read_prev <= 1'b0;
      dcnt          <= 8'd0;
      decim_q       <= 8'd0;
      write_ptr     <= '0;
      write_buf     <= 1'b0;
      has_switched  <= 1'b0;
      overrun_cnt   <= 16'd0;
    end else begin
      trig_prev     <= trig_in;
      reg_read_prev <= reg_read;
      if (enter_fill) begin
        dcnt    <= 8'd0;
        decim_q <= decim;
      end else if (state == S_FILL && bus.sample_valid) begin
        dcnt <= (dcnt == decim_q) ? 8'd0 : dcnt + 8'd1;
      end
      if (swap) begin
        write_buf <= ~write_buf;
        write_ptr <= '0;
      end else if (wr_en && !last_slot) begin
        write_ptr <= write_ptr + AW'(1);
      end
      // A swap in the same cycle as the host releasing the bank keeps the flag set.
      if (swap)                                has_switched <= 1'b1;
      else if (reg_read_prev && !reg_read)     has_switched <= 1'b0;
      if (arm_ok)                              overrun_cnt  <= 16'd0;
      else if (ovr_inc && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] q;
      always_ff @(posedge clk) begin
        if (wr_en && write_buf == 1'(b))
          mem[write_ptr] <= bus.sample_data[c*DATA_WIDTH +: DATA_WIDTH];
        if (bus.rd_en)
          q <= mem[bus.rd_addr];
      end
      assign rd_q[b][c] = q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_ch_q    <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_bank_q <= ~write_buf;
        rd_ch_q   <= bus.rd_ch;
      end
    end
  end

  // Channel indices beyond NUM_CH match no entry and read back as zero.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (rd_ch_q == CW'(c)) rd_word = rd_bank_q ? rd_q[1][c] : rd_q[0][c];
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_valid_q ? 16'(rd_word) : 16'd0;

endmodule

// File: tb/tb_sdma_pingpong_mc.sv
// Bench for sdma_pingpong_mc: a bank-level reference model checked every cycle, plus directed
// scenarios with hand-computed literals for triggers, decimation, deferred swap, continuous mode and reset.
module tb_sdma_pingpong_mc;
  localparam int DW = 12, DEPTH = 1024, NCH = 3, AW = 10, CW = 2;
  localparam int P_IDLE = 0, P_WAIT = 1, P_FILL = 2, P_PEND = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic trig_in = 1'b0, continuous = 1'b0, arm = 1'b0, reg_read = 1'b0;
  logic [1:0] trig_mode = 2'd0;
  logic [7:0] decim = 8'd0;
  logic has_switched, write_buf, busy;
  logic [AW-1:0] write_ptr;
  logic [15:0] overrun_cnt;

  sdma_pingpong_mc_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH)) bus ();

  sdma_pingpong_mc #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .trig_in(trig_in), .trig_mode(trig_mode),
    .continuous(continuous), .arm(arm), .decim(decim), .reg_read(reg_read),
    .has_switched(has_switched), .write_ptr(write_ptr), .write_buf(write_buf),
    .overrun_cnt(overrun_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  bit chk_on = 1'b0;

  // Reference model: banks as plain arrays, decimation as "every (decim+1)-th valid sample since fill start".
  logic [DW-1:0] mmem [2][NCH][DEPTH];
  int ph, e_ptr, e_ovr, e_rdd, nvalid, m_decim;
  bit e_buf, e_hs, e_rdv, e_trig_last, e_rr_last;

  always @(posedge clk) begin
    bit sw, fire;
    if (rst) begin
      ph = P_IDLE; e_ptr = 0; e_buf = 0; e_hs = 0; e_ovr = 0; e_rdv = 0; e_rdd = 0;
      e_trig_last = 0; e_rr_last = 0; nvalid = 0; m_decim = 0;
    end else begin
      e_rdv = bus.rd_en;
      e_rdd = 0;
      if (bus.rd_en && bus.rd_ch < NCH) e_rdd = int'(mmem[!e_buf][bus.rd_ch][bus.rd_addr]);
      sw = 0;
      fire = 0;
      case (ph)
        P_IDLE: if (arm) begin ph = P_WAIT; e_ovr = 0; end
        P_WAIT: begin
          case (trig_mode)
            2'd0: fire = 1;
            2'd1: fire = trig_in && !e_trig_last;
            2'd2: fire = !trig_in && e_trig_last;
            default: fire = trig_in;
          endcase
          if (fire) begin ph = P_FILL; nvalid = 0; m_decim = int'(decim); end
        end
        P_FILL: if (bus.sample_valid) begin
          if (nvalid % (m_decim + 1) == 0) begin
            for (int c = 0; c < NCH; c++) mmem[e_buf][c][e_ptr] = bus.sample_data[c*DW +: DW];
            if (e_ptr == DEPTH - 1) begin
              if (reg_read) ph = P_PEND; else sw = 1;
            end else e_ptr++;
          end
          nvalid++;
        end
        default: begin
          if (bus.sample_valid && e_ovr < 65535) e_ovr++;
          if (!reg_read) sw = 1;
        end
      endcase
      if (sw) begin
        e_buf = !e_buf; e_ptr = 0; e_hs = 1;
        ph = continuous ? P_WAIT : P_IDLE;
      end else if (e_rr_last && !reg_read) e_hs = 0;
      e_trig_last = trig_in;
      e_rr_last = reg_read;
    end
  end

  always @(negedge clk) if (chk_on) begin
    n_tests++;
    if (write_ptr !== AW'(e_ptr) || write_buf !== e_buf || has_switched !== e_hs ||
        overrun_cnt !== 16'(e_ovr) || busy !== (ph != P_IDLE) ||
        bus.rd_valid !== e_rdv || bus.rd_data !== 16'(e_rdd)) begin
      n_fail++;
      $display("FAIL model t=%0t got ptr=%0d buf=%0d hs=%0d ovr=%0d busy=%0d rdv=%0d rdd=%0d want ptr=%0d buf=%0d hs=%0d ovr=%0d busy=%0d rdv=%0d rdd=%0d",
               $time, write_ptr, write_buf, has_switched, overrun_cnt, busy, bus.rd_valid, bus.rd_data,
               e_ptr, e_buf, e_hs, e_ovr, (ph != P_IDLE), e_rdv, e_rdd);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  function automatic logic [NCH*DW-1:0] pack(input int pat, input int i);
    logic [DW-1:0] c0, c1, c2;
    case (pat)
      0:       begin c0 = DW'(2000 + (i >> 6)); c1 = DW'(i); end
      1:       begin c0 = DW'(3000 + (i & 255)); c1 = DW'(i * 3); end
      default: begin c0 = DW'(i ^ 'h5A5); c1 = DW'(i); end
    endcase
    c2 = DW'(i * 7 + pat);
    return {c2, c1, c0};
  endfunction

  task automatic feed(input int n, input int pat);
    for (int i = 0; i < n; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_data  = pack(pat, i);
      tick();
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int ch, input int addr, input int exp);
    bus.rd_en = 1'b1;
    bus.rd_ch = CW'(ch);
    bus.rd_addr = AW'(addr);
    tick();
    bus.rd_en = 1'b0;
    @(negedge clk);
    chk({name, " valid"}, int'(bus.rd_valid), 1);
    chk(name, int'(bus.rd_data), exp);
  endtask

  initial begin
    bus.sample_valid = 1'b0; bus.sample_data = '0;
    bus.rd_en = 1'b0; bus.rd_ch = '0; bus.rd_addr = '0;
    tick(); tick();
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("reset ptr", int'(write_ptr), 0);
    chk("reset buf", int'(write_buf), 0);
    chk("reset hs", int'(has_switched), 0);
    chk("reset ovr", int'(overrun_cnt), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset rdv", int'(bus.rd_valid), 0);

    // Rising-edge trigger, one full bank.
    trig_mode = 2'd1; trig_in = 1'b0;
    pulse_arm(); tick();
    chk("t1 waiting busy", int'(busy), 1);
    trig_in = 1'b1; tick();
    feed(1024, 0);
    chk("t1 hs", int'(has_switched), 1);
    chk("t1 buf", int'(write_buf), 1);
    chk("t1 oneshot busy", int'(busy), 0);
    rd_chk("t1 ch0 a0", 0, 0, 2000);
    rd_chk("t1 ch0 a63", 0, 63, 2000);
    rd_chk("t1 ch0 a64", 0, 64, 2001);
    rd_chk("t1 ch0 a1023", 0, 1023, 2015);
    rd_chk("t1 ch1 a5", 1, 5, 5);
    rd_chk("t1 ch3 out of range", 3, 5, 0);

    // Free-run with decimation by 4.
    trig_mode = 2'd0; decim = 8'd3;
    pulse_arm(); tick();
    feed(4096, 2);
    chk("t2 buf", int'(write_buf), 0);
    chk("t2 busy", int'(busy), 0);
    chk("t2 ptr", int'(write_ptr), 0);
    rd_chk("t2 ch1 a1", 1, 1, 4);
    rd_chk("t2 ch1 a500", 1, 500, 2000);
    rd_chk("t2 ch1 a1023", 1, 1023, 4092);
    rd_chk("t2 ch0 a2", 0, 2, 1453);

    // Swap deferred while the host holds the ready bank.
    decim = 8'd0; reg_read = 1'b1;
    pulse_arm(); tick();
    feed(1024, 0);
    chk("t3 pend ptr", int'(write_ptr), 1023);
    chk("t3 pend buf", int'(write_buf), 0);
    feed(50, 2);
    tick();
    chk("t3 pend ovr", int'(overrun_cnt), 50);
    chk("t3 still pend buf", int'(write_buf), 0);
    reg_read = 1'b0; tick();
    chk("t3 swap buf", int'(write_buf), 1);
    chk("t3 swap ptr", int'(write_ptr), 0);
    chk("t3 swap hs", int'(has_switched), 1);
    chk("t3 ovr held", int'(overrun_cnt), 50);
    reg_read = 1'b1; tick(); reg_read = 1'b0; tick();
    chk("t3 hs cleared", int'(has_switched), 0);

    // Continuous re-arm for three banks, last one ends in IDLE.
    continuous = 1'b1;
    pulse_arm();
    chk("t4 arm clears ovr", int'(overrun_cnt), 0);
    tick();
    for (int b = 0; b < 3; b++) begin
      if (b == 2) continuous = 1'b0;
      feed(1024, 2);
      chk("t4 buf", int'(write_buf), (b % 2 == 0) ? 0 : 1);
      chk("t4 busy", int'(busy), (b < 2) ? 1 : 0);
      reg_read = 1'b1; tick(); reg_read = 1'b0; tick();
      chk("t4 hs after host", int'(has_switched), 0);
    end

    // Falling-edge mode held high, then level mode held low.
    trig_mode = 2'd2; trig_in = 1'b1;
    pulse_arm();
    feed(20, 0);
    chk("t5 fall held ptr", int'(write_ptr), 0);
    chk("t5 fall held busy", int'(busy), 1);
    trig_in = 1'b0; tick();
    feed(10, 0);
    chk("t5 fall fill ptr", int'(write_ptr), 10);
    rst = 1'b1; tick(); rst = 1'b0;
    trig_mode = 2'd3;
    pulse_arm();
    feed(30, 0);
    chk("t5 level low ptr", int'(write_ptr), 0);
    chk("t5 level low busy", int'(busy), 1);
    trig_in = 1'b1; tick();
    feed(7, 0);
    chk("t5 level fill ptr", int'(write_ptr), 7);
    rst = 1'b1; tick(); rst = 1'b0;

    // Reset mid-fill, then refill from address 0.
    trig_mode = 2'd0;
    pulse_arm(); tick();
    feed(1024, 2);
    pulse_arm(); tick();
    feed(300, 0);
    chk("t6 pre ptr", int'(write_ptr), 300);
    chk("t6 pre buf", int'(write_buf), 1);
    rst = 1'b1; bus.rd_en = 1'b1;
    tick();
    rst = 1'b0; bus.rd_en = 1'b0;
    chk("t6 rst ptr", int'(write_ptr), 0);
    chk("t6 rst buf", int'(write_buf), 0);
    chk("t6 rst hs", int'(has_switched), 0);
    chk("t6 rst ovr", int'(overrun_cnt), 0);
    chk("t6 rst busy", int'(busy), 0);
    chk("t6 rst rdv", int'(bus.rd_valid), 0);
    chk("t6 rst rdd", int'(bus.rd_data), 0);
    pulse_arm(); tick();
    feed(1024, 1);
    chk("t6 refill buf", int'(write_buf), 1);
    rd_chk("t6 ch0 a0", 0, 0, 3000);
    rd_chk("t6 ch0 a300", 0, 300, 3044);
    rd_chk("t6 ch1 a1", 1, 1, 3);
    tick();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sdma_pingpong_mc.md
Name: sdma_pingpong_mc

Overview:
- Parametrised multi-channel ping-pong capture buffer. It is the next-generation replacement for the single-channel dual buffer inside sdma.
- Captures NUM_CH parallel ADC sample streams into two banks. On a trigger, one bank fills while the MCU reads the other bank over FSMC.
- New features: selectable trigger modes, sample decimation, one-shot/continuous operation, overrun counting and swap deferral while the host is reading.
- Sits between the ADC sampling front end (sample strobe already in clk domain) and the FSMC register/address decoder.

Parameters:
- DATA_WIDTH, 12, bits per sample.
- DEPTH, 1024, samples per channel per bank; must be a power of two, at least 4.
- NUM_CH, 2, number of parallel channels, 1..8.
- AW, $clog2(DEPTH), local address width (localparam).
- CW, max($clog2(NUM_CH),1), local channel-select width (localparam).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sample_valid  in  1  one-cycle strobe: sample_data is valid this cycle.
- sample_data  in  NUM_CH*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- trig_in  in  1  trigger source (signal_in, already synchronised).
- trig_mode  in  2  0 = free-run, 1 = rising edge, 2 = falling edge, 3 = high level.
- continuous  in  1  1 = re-arm automatically after each swap; 0 = one-shot.
- arm  in  1  one-cycle pulse; starts acquisition from IDLE.
- decim  in  8  keep 1 of every decim+1 valid samples.
- reg_read  in  1  host-busy flag written at FSMC address 0x4000: 1 = MCU reading the ready bank.
- rd_en  in  1  read request.
- rd_ch  in  CW  channel to read.
- rd_addr  in  AW  sample index to read.
- rd_data  out  16  zero-extended sample from the ready bank.
- rd_valid  out  1  rd_data valid.
- has_switched  out  1  sticky; a full bank is ready for the host.
- write_ptr  out  AW  current fill index.
- write_buf  out  1  bank currently being filled.
- overrun_cnt  out  16  samples dropped while a swap was deferred; saturates at 0xFFFF.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, decimation counter 0, previous-trigger register 0.
- States:
  - IDLE: leave on an arm pulse, to WAIT_TRIG.
  - WAIT_TRIG: leave to FILL on the trigger condition.
    - Free-run fires immediately on the next cycle.
    - Edge modes compare trig_in with its value registered one cycle earlier.
    - Level mode fires while trig_in is 1.
  - FILL: on each kept sample, write all NUM_CH channels at write_ptr in bank write_buf in the same cycle, then increment write_ptr. A write with write_ptr = DEPTH-1 completes the bank:
    - If reg_read = 0: swap in the same cycle. write_buf toggles, write_ptr goes to 0, has_switched goes to 1. Next state is WAIT_TRIG if continuous = 1, otherwise IDLE.
    - If reg_read = 1: go to SWAP_PEND.
  - SWAP_PEND: every sample_valid increments overrun_cnt (saturating); no memory write. When reg_read = 0, perform the swap actions above, then go to the next state as above.
- Decimation:
  - Counter resets to 0 on entry to FILL.
  - A valid sample is kept when the counter is 0. The counter then counts up and wraps at decim.
  - decim = 0 keeps every sample.
  - decim is sampled only on entry to FILL.
- has_switched clears on the falling edge of reg_read (host finished reading). If a falling edge and a swap fall in the same cycle, the swap wins and has_switched stays 1.
- Read path:
  - Reads always target bank ~write_buf.
  - Latency is exactly 1 cycle: rd_en at cycle N gives rd_data and rd_valid = 1 at cycle N+1. rd_valid is 0 otherwise.
  - rd_ch >= NUM_CH returns 0 with rd_valid = 1.
  - Reads are independent of the write path; there is no back-pressure.
- Memory: 2*NUM_CH simple dual-port RAMs of DEPTH x DATA_WIDTH with a synchronous read, inferable to M9K.
- An arm pulse outside IDLE is ignored. rst asserted in any state returns everything to reset values on the next edge; RAM contents are not cleared.
- overrun_cnt clears only on rst or an arm pulse accepted in IDLE.
- write_ptr wraps only through the swap; it never exceeds DEPTH-1.

Test Plan:
- Reset, arm, trig_mode = 1, rising edge on trig_in. Feed 1024 valid samples on ch0 (2000+(i>>6)) and ch1 (i). Expect:
  - has_switched = 1 and write_buf = 1.
  - Read ch0 at addr 0/63/64/1023 gives 2000/2000/2001/2015; read ch1 at addr 5 gives 5, each with 1-cycle latency.
- decim = 3 in free-run, 4096 valid samples. Expect exactly one swap; ch1 addr k reads 4k.
- Hold reg_read = 1 through bank completion, then 50 more valid samples, then drop reg_read. Expect:
  - Swap occurs on the cycle reg_read falls.
  - overrun_cnt = 50.
  - Next bank starts at write_ptr 0.
- continuous = 1, reg_read pulsed after each swap for 3 banks. Expect write_buf toggles 1→0→1 and busy stays 1; with continuous = 0, expect busy = 0 after the first swap.
- trig_mode = 2 with trig_in held high: no fill; falling edge starts the fill. trig_mode = 3 with trig_in low stays in WAIT_TRIG indefinitely.
- rst asserted mid-FILL at write_ptr = 300. Expect all outputs 0 on the next cycle, and a subsequent arm+trigger fills from addr 0.
